// File: rtl/seq_det_param.sv
// seq_det_param: detects a run-time programmable PAT_LEN-word sequence on a qualified stream.
// Define SEQ_DET_PARAM_CNT_EN to build the saturating MATCH_CNT hit counter.
module seq_det_param #(
   parameter int DATA_W = 8,
   parameter int PAT_LEN = 4,
   parameter logic [PAT_LEN*DATA_W-1:0] PATTERN = 32'h3CA53CA5,
   parameter int CNT_W = 8,
   localparam int IDX_W = $clog2(PAT_LEN),
   localparam int FILL_W = $clog2(PAT_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              d_valid,
   input  logic [DATA_W-1:0] d_in,
   input  logic              overlap,
   input  logic              pat_we,
   input  logic [IDX_W-1:0]  pat_idx,
   input  logic [DATA_W-1:0] pat_wdata,
   input  logic              cnt_clr,
   output logic              match,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [FILL_W-1:0] fill
);

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PARTIAL,
      ST_ARMED
   } det_state_t;

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

   logic [DATA_W-1:0] pat_q  [PAT_LEN];
   logic [DATA_W-1:0] hist_q [PAT_LEN-1];
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              match_q;
   logic              win_eq;
   logic              hit;
   logic              shift_en;
   logic              hist_clr;
   logic              idx_ok;
   det_state_t        state;

   // The detection state is fully encoded by the fill level.
   always_comb begin
      if (fill_q == '0)
         state = ST_EMPTY;
      else if (fill_q == FILL_MAX)
         state = ST_ARMED;
      else
         state = ST_PARTIAL;
   end

   // Window is history (oldest first) followed by the word on d_in.
   always_comb begin
      win_eq = (d_in == pat_q[PAT_LEN-1]);
      for (int i = 0; i < PAT_LEN - 1; i++)
         if (hist_q[i] != pat_q[i])
            win_eq = 1'b0;
   end

   assign idx_ok = (int'(pat_idx) < PAT_LEN);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      hit      = 1'b0;
      shift_en = 1'b0;
      hist_clr = 1'b0;
      fill_d   = fill_q;
      if (pat_we) begin
         hist_clr = 1'b1;
         fill_d   = '0;
      end else if (d_valid) begin
         hit = (state == ST_ARMED) && win_eq;
         if (hit && !overlap) begin
            hist_clr = 1'b1;
            fill_d   = '0;
         end else begin
            shift_en = 1'b1;
            if (state != ST_ARMED)
               fill_d = fill_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_q  <= '0;
         match_q <= 1'b0;
      end else begin
         fill_q  <= fill_d;
         match_q <= hit;
      end
   end

   // NOTE: pattern and history arrays are reset element by element; the pattern must come up as PATTERN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PAT_LEN; i++)
            pat_q[i] <= PATTERN[i*DATA_W +: DATA_W];
      end else if (pat_we && idx_ok) begin
         pat_q[pat_idx] <= pat_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PAT_LEN - 1; i++)
            hist_q[i] <= '0;
      end else if (hist_clr) begin
         for (int i = 0; i < PAT_LEN - 1; i++)
            hist_q[i] <= '0;
      end else if (shift_en) begin
         for (int i = 0; i < PAT_LEN - 2; i++)
            hist_q[i] <= hist_q[i+1];
         hist_q[PAT_LEN-2] <= d_in;
      end
   end

`ifdef SEQ_DET_PARAM_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Clear has priority over a coincident hit; the count sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (cnt_clr)
         cnt_q <= '0;
      else if (hit && (cnt_q != '1))
         cnt_q <= cnt_q + 1'b1;
   end

   assign match_cnt = cnt_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr;
   assign match_cnt      = '0;
`endif

   assign match = match_q;
   assign fill  = fill_q;

endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised successor to the team's fixed 8-bit sequence detector. Watches a qualified word stream for a run-time-programmable sequence of PAT_LEN words of DATA_W bits, with selectable overlapping/non-overlapping detection and an optional saturating match counter. Sits between a byte/word source and control logic that needs a one-cycle detection strobe.

## Interface
- DATA_W, 8, width of each stream word and pattern element
- PAT_LEN, 4, words per pattern (2..16)
- PATTERN, 32'h3CA53CA5, reset pattern; element i at bits [i*DATA_W +: DATA_W]; element 0 is the first word of the sequence
- CNT_W, 8, width of MATCH_CNT
- CLK  in  1  clock, rising-edge
- RST  in  1  asynchronous, active-low reset
- D_VALID  in  1  D_IN qualifier; word consumed on rising CLK when 1
- D_IN  in  DATA_W  stream word
- OVERLAP  in  1  1 = overlapping detection, 0 = non-overlapping
- PAT_WE  in  1  pattern element write strobe
- PAT_IDX  in  $clog2(PAT_LEN)  element index for write
- PAT_WDATA  in  DATA_W  element value for write
- CNT_CLR  in  1  synchronous clear of MATCH_CNT
- MATCH  out  1  registered one-cycle detection pulse
- MATCH_CNT  out  CNT_W  saturating count of MATCH pulses
- FILL  out  $clog2(PAT_LEN+1)  words currently held in history (0..PAT_LEN-1)

## Operation
- Storage: pattern register (PAT_LEN x DATA_W), history shift register (PAT_LEN-1 words, newest last), fill counter.
- Detection states by FILL: EMPTY (0), PARTIAL (1..PAT_LEN-2), ARMED (PAT_LEN-1).
- Valid beat, no PAT_WE: window = history (oldest first) + D_IN. Hit when state ARMED and window[i] == pattern[i] for all i.
- Hit, OVERLAP=1: MATCH=1 next cycle; history shifts in D_IN; state stays ARMED.
- Hit, OVERLAP=0: MATCH=1 next cycle; history discarded, FILL=0 (EMPTY).
- Non-hit beat: history shifts in D_IN; FILL increments to saturate at PAT_LEN-1 (EMPTY->PARTIAL->ARMED, ARMED stays).
- D_VALID=0: history, FILL unchanged; MATCH=0 next cycle. Gaps never break a sequence.
- PAT_WE=1: pattern[PAT_IDX] <= PAT_WDATA; history cleared, FILL=0; any simultaneous valid beat discarded; MATCH=0 next cycle. PAT_IDX >= PAT_LEN: write ignored, history still cleared.
- OVERLAP sampled per beat; changing it never alters stored history.

## Timing
- Reset (RST=0, async): MATCH=0, MATCH_CNT=0, FILL=0, history=0, pattern=PATTERN. Mid-sequence reset aborts partial match; no MATCH after release until PAT_LEN fresh matching beats.
- Latency: MATCH rises in the cycle after the rising edge sampling the completing word; lasts exactly one cycle per hit.
- Back-to-back hits (OVERLAP=1, periodic pattern) give MATCH on consecutive eligible beats.
- Pattern write takes effect for beats sampled on the following edge.
- MATCH_CNT updates on the same edge MATCH rises.

## Configuration
- SEQ_DET_PARAM_CNT_EN defined: MATCH_CNT increments on each hit, saturates at 2^CNT_W-1; CNT_CLR=1 forces 0 next edge, clear wins over a simultaneous hit.
- Not defined: counter not built; MATCH_CNT tied to 0, CNT_CLR ignored. Detection behaviour identical.

## Test plan
- Reset then OVERLAP=1, beats A5,3C,A5,3C,A5,3C consecutive -> MATCH pulses after beats 4 and 6, MATCH_CNT=2, FILL=3 at end.
- Same stream, OVERLAP=0 -> single MATCH after beat 4, FILL=2 at end, MATCH_CNT=1.
- Beats A5,3C,A5,3C with D_VALID low 3 cycles between each -> one MATCH after 4th valid beat; no MATCH during gaps.
- Beats A5,3C,A5, assert RST=0 for one cycle, then 3C -> no MATCH; then A5,3C,A5,3C -> MATCH, FILL=0 on OVERLAP=0.
- PAT_WE idx 3 data FF concurrent with valid beat -> beat dropped, FILL=0; then A5,3C,A5,FF -> MATCH; A5,3C,A5,3C -> no MATCH.
- SEQ_DET_PARAM_CNT_EN, CNT_W=2, OVERLAP=1, 5 hits -> MATCH_CNT 1,2,3,3,3; CNT_CLR with hit -> 0; without macro MATCH_CNT stays 0 throughout.
